// File: rtl/l2_port_arbiter.sv
// Shares the single L2 line port between the L1 I-cache and D-cache; D-cache has priority
// with a starvation limit for the I-cache. Performance counters exist only with `define ARB_PERF_CNT_EN.
module l2_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int ADDR_W       = 16,
  parameter int LINE_W       = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_address,
  input  logic [LINE_W-1:0] i_wdata,
  output logic              i_resp,
  output logic [LINE_W-1:0] i_rdata,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_resp,
  output logic [LINE_W-1:0] d_rdata,
  output logic              l2_read,
  output logic              l2_write,
  output logic [ADDR_W-1:0] l2_address,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic              l2_resp,
  input  logic [LINE_W-1:0] l2_rdata,
  output logic [1:0]        owner,
  output logic [15:0]       i_grants,
  output logic [15:0]       d_grants,
  output logic [15:0]       conflicts
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [3:0] STREAK_MAX = 4'(STARVE_LIMIT);
  localparam logic [1:0] OWN_NONE   = 2'b00;
  localparam logic [1:0] OWN_I      = 2'b01;
  localparam logic [1:0] OWN_D      = 2'b10;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [ADDR_W-1:0] addr_r;
  logic [LINE_W-1:0] wdata_r;
  logic              l2_read_r;
  logic              l2_write_r;
  logic [1:0]        owner_r;
  logic [3:0]        streak_r;
  logic              i_req_s;
  logic              d_req_s;
  logic              grant_i_s;
  logic              grant_d_s;
  logic              done_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [LINE_W-1:0] sel_wdata_s;
  logic              sel_write_s;

  assign i_req_s = i_read | i_write;
  assign d_req_s = d_read | d_write;

  // Next-state decode and grant selection
  always_comb begin
    state_nxt_s = state_r;
    grant_i_s   = 1'b0;
    grant_d_s   = 1'b0;
    done_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (i_req_s && d_req_s) begin
          if (streak_r == STREAK_MAX) begin
            grant_i_s = 1'b1;
          end else begin
            grant_d_s = 1'b1;
          end
        end else if (i_req_s) begin
          grant_i_s = 1'b1;
        end else if (d_req_s) begin
          grant_d_s = 1'b1;
        end else begin
          grant_i_s = 1'b0;
          grant_d_s = 1'b0;
        end
        if (grant_i_s) begin
          state_nxt_s = GRANT_I;
        end else if (grant_d_s) begin
          state_nxt_s = GRANT_D;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      GRANT_I, GRANT_D: begin
        if (l2_resp) begin
          done_s      = 1'b1;
          state_nxt_s = RELEASE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      RELEASE: state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Request fields of the cache being granted this cycle
  always_comb begin
    if (grant_i_s) begin
      sel_addr_s  = i_address;
      sel_wdata_s = i_wdata;
      sel_write_s = i_write;
    end else begin
      sel_addr_s  = d_address;
      sel_wdata_s = d_wdata;
      sel_write_s = d_write;
    end
  end

  // State register, latched request and L2 strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      addr_r     <= {ADDR_W{1'b0}};
      wdata_r    <= {LINE_W{1'b0}};
      l2_read_r  <= 1'b0;
      l2_write_r <= 1'b0;
      owner_r    <= OWN_NONE;
    end else begin
      state_r <= state_nxt_s;
      if (grant_i_s || grant_d_s) begin
        addr_r     <= sel_addr_s;
        wdata_r    <= sel_wdata_s;
        l2_write_r <= sel_write_s;
        l2_read_r  <= ~sel_write_s;  // write wins when both ops are asserted
        owner_r    <= grant_i_s ? OWN_I : OWN_D;
      end else if (done_s) begin
        l2_read_r  <= 1'b0;
        l2_write_r <= 1'b0;
        owner_r    <= OWN_NONE;
      end else begin
        l2_read_r  <= l2_read_r;
        l2_write_r <= l2_write_r;
        owner_r    <= owner_r;
      end
    end
  end

  // Consecutive D grants while the I-cache is kept waiting
  always_ff @(posedge clk) begin
    if (rst) begin
      streak_r <= 4'd0;
    end else if (grant_i_s) begin
      streak_r <= 4'd0;
    end else if (grant_d_s) begin
      if (i_req_s) begin
        streak_r <= (streak_r == STREAK_MAX) ? STREAK_MAX : streak_r + 4'd1;
      end else begin
        streak_r <= 4'd0;
      end
    end else begin
      streak_r <= streak_r;
    end
  end

  assign l2_read    = l2_read_r;
  assign l2_write   = l2_write_r;
  assign l2_address = addr_r;
  assign l2_wdata   = wdata_r;
  assign owner      = owner_r;
  assign i_resp     = (state_r == GRANT_I) & l2_resp;
  assign d_resp     = (state_r == GRANT_D) & l2_resp;
  assign i_rdata    = l2_rdata;
  assign d_rdata    = l2_rdata;

`ifdef ARB_PERF_CNT_EN
  logic [15:0] i_grants_r;
  logic [15:0] d_grants_r;
  logic [15:0] conflicts_r;
  logic        conflict_s;

  assign conflict_s = (state_r == IDLE) & i_req_s & d_req_s;

  // Saturating grant and contention counters
  always_ff @(posedge clk) begin
    if (rst) begin
      i_grants_r  <= 16'd0;
      d_grants_r  <= 16'd0;
      conflicts_r <= 16'd0;
    end else begin
      if (grant_i_s && (i_grants_r != 16'hFFFF)) begin
        i_grants_r <= i_grants_r + 16'd1;
      end
      if (grant_d_s && (d_grants_r != 16'hFFFF)) begin
        d_grants_r <= d_grants_r + 16'd1;
      end
      if (conflict_s && (conflicts_r != 16'hFFFF)) begin
        conflicts_r <= conflicts_r + 16'd1;
      end
    end
  end

  assign i_grants  = i_grants_r;
  assign d_grants  = d_grants_r;
  assign conflicts = conflicts_r;
`else
  assign i_grants  = 16'd0;
  assign d_grants  = 16'd0;
  assign conflicts = 16'd0;
`endif

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Self-checking bench for l2_port_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level arbitration model.
module tb_l2_port_arbiter;
  localparam int STARVE_LIMIT = 4;
  localparam int ADDR_W       = 16;
  localparam int LINE_W       = 128;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_read, i_write, d_read, d_write;
  logic [ADDR_W-1:0] i_address, d_address;
  logic [LINE_W-1:0] i_wdata, d_wdata;
  logic              i_resp, d_resp;
  logic [LINE_W-1:0] i_rdata, d_rdata;
  logic              l2_read, l2_write, l2_resp;
  logic [ADDR_W-1:0] l2_address;
  logic [LINE_W-1:0] l2_wdata, l2_rdata;
  logic [1:0]        owner;
  logic [15:0]       i_grants, d_grants, conflicts;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  l2_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_write(i_write), .i_address(i_address), .i_wdata(i_wdata),
    .i_resp(i_resp), .i_rdata(i_rdata),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_resp(d_resp), .d_rdata(d_rdata),
    .l2_read(l2_read), .l2_write(l2_write), .l2_address(l2_address), .l2_wdata(l2_wdata),
    .l2_resp(l2_resp), .l2_rdata(l2_rdata),
    .owner(owner), .i_grants(i_grants), .d_grants(d_grants), .conflicts(conflicts)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_read = 1'b0; i_write = 1'b0; i_address = 16'h0; i_wdata = 128'h0;
    d_read = 1'b0; d_write = 1'b0; d_address = 16'h0; d_wdata = 128'h0;
    l2_resp = 1'b0; l2_rdata = 128'h0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Waits (bounded) for a grant, then answers it with a one-cycle l2_resp.
  task automatic run_txn(output logic [1:0] got_owner, output bit ok);
    int n = 0;
    do begin
      step();
      n++;
    end while (owner == 2'b00 && n < 6);
    got_owner = owner;
    ok = (owner != 2'b00);
    l2_resp = 1'b1;
    step();
    l2_resp = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    i_read = 1'b1; i_address = 16'h1234; d_write = 1'b1; d_address = 16'h5678;
    rst = 1'b1;
    step();
    step();
    total++;
    if (owner !== 2'b00 || l2_read !== 1'b0 || l2_write !== 1'b0) begin
      bad++; $display("FAIL reset_strobes: owner=%b rd=%b wr=%b want 00/0/0", owner, l2_read, l2_write);
    end
    total++;
    if (l2_address !== 16'h0 || l2_wdata !== 128'h0) begin
      bad++; $display("FAIL reset_latches: addr=%h wdata=%h want 0", l2_address, l2_wdata);
    end
    total++;
    if (i_resp !== 1'b0 || d_resp !== 1'b0) begin
      bad++; $display("FAIL reset_resp: i=%b d=%b want 0/0", i_resp, d_resp);
    end
    total++;
    if (i_grants !== 16'd0 || d_grants !== 16'd0 || conflicts !== 16'd0) begin
      bad++; $display("FAIL reset_counters: %0d %0d %0d want 0", i_grants, d_grants, conflicts);
    end
    rst = 1'b0;
    clear_inputs();
  endtask

  task automatic test_reset_mid_read();
    apply_reset();
    i_read = 1'b1; i_address = 16'h1000;
    step();
    total++;
    if (l2_read !== 1'b1 || owner !== 2'b01 || l2_address !== 16'h1000) begin
      bad++; $display("FAIL midrst_grant: rd=%b owner=%b addr=%h want 1/01/1000", l2_read, owner, l2_address);
    end
    step();
    rst = 1'b1; i_read = 1'b0;
    step();
    total++;
    if (l2_read !== 1'b0 || owner !== 2'b00) begin
      bad++; $display("FAIL midrst_abort: rd=%b owner=%b want 0/00", l2_read, owner);
    end
    rst = 1'b0;
    step();
    l2_resp = 1'b1;
    #1;
    total++;
    if (i_resp !== 1'b0 || d_resp !== 1'b0) begin
      bad++; $display("FAIL midrst_late_resp: i=%b d=%b want 0/0", i_resp, d_resp);
    end
    step();
    l2_resp = 1'b0;
    total++;
    if (owner !== 2'b00 || l2_read !== 1'b0) begin
      bad++; $display("FAIL midrst_idle: owner=%b rd=%b want 00/0", owner, l2_read);
    end
  endtask

  task automatic test_single_read();
    logic [LINE_W-1:0] rd;
    rd = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;
    apply_reset();
    i_read = 1'b1; i_address = 16'h3040;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c == 5) begin l2_resp = 1'b1; l2_rdata = rd; end
      if (c == 6) begin l2_resp = 1'b0; i_read = 1'b0; end
      #1;
      total++;
      if (l2_read !== (c <= 5) || owner !== ((c <= 5) ? 2'b01 : 2'b00)) begin
        bad++; $display("FAIL single_strobe c=%0d: rd=%b owner=%b want %b", c, l2_read, owner, (c <= 5));
      end
      total++;
      if (i_resp !== (c == 5) || d_resp !== 1'b0) begin
        bad++; $display("FAIL single_resp c=%0d: i=%b d=%b want %b/0", c, i_resp, d_resp, (c == 5));
      end
      if (c <= 5) begin
        total++;
        if (l2_address !== 16'h3040 || l2_write !== 1'b0) begin
          bad++; $display("FAIL single_addr c=%0d: addr=%h wr=%b want 3040/0", c, l2_address, l2_write);
        end
      end
      if (c == 5) begin
        total++;
        if (i_rdata !== rd) begin
          bad++; $display("FAIL single_rdata: got %h want %h", i_rdata, rd);
        end
      end
    end
  endtask

  task automatic test_addr_stability();
    logic [LINE_W-1:0] pat_a;
    pat_a = {4{32'hA5A5_5A5A}};
    apply_reset();
    d_write = 1'b1; d_address = 16'h8000; d_wdata = pat_a;
    for (int c = 1; c <= 4; c++) begin
      step();
      if (c == 1) begin d_address = 16'h9000; d_wdata = ~pat_a; end
      if (c == 4) l2_resp = 1'b1;
      #1;
      total++;
      if (l2_address !== 16'h8000 || l2_wdata !== pat_a || l2_write !== 1'b1 || l2_read !== 1'b0) begin
        bad++; $display("FAIL stable c=%0d: addr=%h wr=%b rd=%b wdata=%h", c, l2_address, l2_write, l2_read, l2_wdata);
      end
      if (c == 4) begin
        total++;
        if (d_resp !== 1'b1 || i_resp !== 1'b0) begin
          bad++; $display("FAIL stable_resp: d=%b i=%b want 1/0", d_resp, i_resp);
        end
      end
    end
    step();
    l2_resp = 1'b0; d_write = 1'b0;
    total++;
    if (owner !== 2'b00 || l2_write !== 1'b0) begin
      bad++; $display("FAIL stable_release: owner=%b wr=%b want 00/0", owner, l2_write);
    end
  endtask

  task automatic test_rw_same();
    apply_reset();
    d_read = 1'b1; d_write = 1'b1; d_address = 16'h0ABC;
    step();
    total++;
    if (l2_write !== 1'b1 || l2_read !== 1'b0 || owner !== 2'b10) begin
      bad++; $display("FAIL rw_same: wr=%b rd=%b owner=%b want 1/0/10", l2_write, l2_read, owner);
    end
    l2_resp = 1'b1;
    step();
    l2_resp = 1'b0; d_read = 1'b0; d_write = 1'b0;
    step();
  endtask

  task automatic test_starvation();
    logic [1:0] want;
    int n;
    apply_reset();
    i_read = 1'b1; i_address = 16'h1111;
    d_read = 1'b1; d_address = 16'h2222;
    for (int g = 1; g <= 10; g++) begin
      n = 0;
      do begin
        step();
        n++;
      end while (owner == 2'b00 && n < 5);
      want = ((g % (STARVE_LIMIT + 1)) == 0) ? 2'b01 : 2'b10;
      total++;
      if (owner !== want) begin
        bad++; $display("FAIL starve_order g=%0d: owner=%b want %b", g, owner, want);
      end
      l2_resp = 1'b1;
      step();
      l2_resp = 1'b0;
      total++;
      if (owner !== 2'b00 || l2_read !== 1'b0) begin
        bad++; $display("FAIL starve_bubble g=%0d: owner=%b rd=%b want 00/0", g, owner, l2_read);
      end
    end
    clear_inputs();
  endtask

  task automatic test_counters();
    logic [1:0] got;
    bit ok;
    apply_reset();
    i_read = 1'b1; i_address = 16'h4000;
    d_read = 1'b1; d_address = 16'h5000;
    for (int t = 0; t < 5; t++) begin
      if (t == 3) i_read = 1'b0;
      run_txn(got, ok);
      total++;
      if (!ok || got !== 2'b10) begin
        bad++; $display("FAIL cnt_grant t=%0d: owner=%b want 10", t, got);
      end
    end
`ifdef ARB_PERF_CNT_EN
    total++;
    if (d_grants !== 16'd5 || i_grants !== 16'd0 || conflicts !== 16'd3) begin
      bad++; $display("FAIL counters: d=%0d i=%0d c=%0d want 5/0/3", d_grants, i_grants, conflicts);
    end
`else
    total++;
    if (d_grants !== 16'd0 || i_grants !== 16'd0 || conflicts !== 16'd0) begin
      bad++; $display("FAIL counters_off: d=%0d i=%0d c=%0d want 0", d_grants, i_grants, conflicts);
    end
`endif
    clear_inputs();
  endtask

  // Randomized traffic against a transaction-level model of the arbitration rules.
  task automatic test_random();
    int                ph;           // 0 waiting for a grant, 1 transaction open, 2 bubble
    int                lat, streak_m, n_i, n_d, n_c, r;
    bit                i_done, d_done, resp_now;
    logic [1:0]        exp_owner;
    logic [ADDR_W-1:0] exp_addr;
    logic [LINE_W-1:0] exp_wdata, rd;
    logic              exp_wr;
    apply_reset();
    ph = 0; lat = 0; streak_m = 0; n_i = 0; n_d = 0; n_c = 0;
    i_done = 1'b0; d_done = 1'b0;
    exp_owner = 2'b00; exp_addr = 16'h0; exp_wdata = 128'h0; exp_wr = 1'b0; rd = 128'h0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      step();
      if (ph == 1) begin
        total++;
        if (owner !== exp_owner || l2_write !== exp_wr || l2_read !== !exp_wr ||
            l2_address !== exp_addr || l2_wdata !== exp_wdata) begin
          bad++; $display("FAIL rnd_grant cyc=%0d: owner=%b/%b wr=%b/%b rd=%b addr=%h/%h", cyc,
                          owner, exp_owner, l2_write, exp_wr, l2_read, l2_address, exp_addr);
        end
      end else begin
        total++;
        if (owner !== 2'b00 || l2_read !== 1'b0 || l2_write !== 1'b0) begin
          bad++; $display("FAIL rnd_idle cyc=%0d: owner=%b rd=%b wr=%b want 00/0/0", cyc, owner, l2_read, l2_write);
        end
      end
      if (i_done) begin i_done = 1'b0; i_read = 1'b0; i_write = 1'b0; end
      if (d_done) begin d_done = 1'b0; d_read = 1'b0; d_write = 1'b0; end
      if (!(i_read || i_write) && $urandom_range(2) == 0) begin
        r = $urandom_range(2);
        i_read = (r != 1); i_write = (r != 0);
        i_address = 16'($urandom);
        i_wdata = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
      if (!(d_read || d_write) && $urandom_range(2) == 0) begin
        r = $urandom_range(2);
        d_read = (r != 1); d_write = (r != 0);
        d_address = 16'($urandom);
        d_wdata = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
      resp_now = 1'b0;
      if (ph == 1) begin
        if ($urandom_range(3) == 0) begin
          if (exp_owner == 2'b01) i_address = 16'($urandom);
          else d_wdata = {$urandom(), $urandom(), $urandom(), $urandom()};
        end
        if (lat == 0) begin
          resp_now = 1'b1;
          l2_resp = 1'b1;
        end else begin
          lat--;
          l2_resp = 1'b0;
        end
      end else begin
        l2_resp = ($urandom_range(3) == 0);
      end
      rd = {$urandom(), $urandom(), $urandom(), $urandom()};
      l2_rdata = rd;
      #1;
      total++;
      if (i_resp !== (resp_now && exp_owner == 2'b01) || d_resp !== (resp_now && exp_owner == 2'b10)) begin
        bad++; $display("FAIL rnd_resp cyc=%0d: i=%b d=%b resp_now=%b owner=%b", cyc, i_resp, d_resp, resp_now, exp_owner);
      end
      total++;
      if (i_rdata !== rd || d_rdata !== rd) begin
        bad++; $display("FAIL rnd_rdata cyc=%0d: i=%h d=%h want %h", cyc, i_rdata, d_rdata, rd);
      end
      case (ph)
        0: begin
          if ((i_read || i_write) || (d_read || d_write)) begin
            if ((i_read || i_write) && (d_read || d_write)) begin
              n_c++;
              exp_owner = (streak_m == STARVE_LIMIT) ? 2'b01 : 2'b10;
            end else begin
              exp_owner = (i_read || i_write) ? 2'b01 : 2'b10;
            end
            if (exp_owner == 2'b01) begin
              exp_addr = i_address; exp_wdata = i_wdata; exp_wr = i_write;
              streak_m = 0; n_i++;
            end else begin
              exp_addr = d_address; exp_wdata = d_wdata; exp_wr = d_write;
              streak_m = (i_read || i_write) ? ((streak_m < STARVE_LIMIT) ? streak_m + 1 : STARVE_LIMIT) : 0;
              n_d++;
            end
            lat = $urandom_range(4);
            ph = 1;
          end
        end
        1: begin
          if (resp_now) begin
            if (exp_owner == 2'b01) i_done = 1'b1; else d_done = 1'b1;
            ph = 2;
          end
        end
        default: ph = 0;
      endcase
    end
    l2_resp = 1'b0;
`ifdef ARB_PERF_CNT_EN
    total++;
    if (i_grants !== 16'(n_i) || d_grants !== 16'(n_d) || conflicts !== 16'(n_c)) begin
      bad++; $display("FAIL rnd_counters: i=%0d/%0d d=%0d/%0d c=%0d/%0d", i_grants, n_i, d_grants, n_d, conflicts, n_c);
    end
`endif
    total++;
    if (n_i == 0 || n_d == 0) begin
      bad++; $display("FAIL rnd_coverage: i grants=%0d d grants=%0d want both nonzero", n_i, n_d);
    end
    clear_inputs();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_reset_mid_read();
    test_single_read();
    test_addr_stability();
    test_rw_same();
    test_starvation();
    test_counters();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
